// File: rtl/apu_arb_pkg.sv
// Shared types and default widths for the APU event arbiter.
//   arb_state_t : arbiter FSM states (IDLE between packets, PASS while forwarding)
//   DATA_W      : default TDATA width
//   TID_W       : default TID (BCID) width
//   KEEP_W      : default TSTRB/TKEEP width
package apu_arb_pkg;

  typedef enum logic {IDLE, PASS} arb_state_t;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned TID_W  = 11;
  localparam int unsigned KEEP_W = DATA_W / 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i  : request vector, one bit per requester
//   last_i : index of the most recent winner; the scan starts just after it, with wrap
//   any_o  : at least one request is set
//   idx_o  : index of the winning request (0 when any_o is low)
module rr_pick #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic                 any_o,
  output logic [$clog2(N)-1:0] idx_o
);

  localparam int unsigned IdxW = $clog2(N);

  always_comb begin
    int unsigned c;
    c     = 0;
    any_o = 1'b0;
    idx_o = '0;
    for (int unsigned k = 0; k < N; k++) begin
      // Modulo keeps the scan legal when N is not a power of two.
      c = (32'(last_i) + 1 + k) % N;
      if (!any_o && req_i[c]) begin
        any_o = 1'b1;
        idx_o = IdxW'(c);
      end
    end
  end

endmodule

// File: rtl/apu_event_arbiter.sv
// Shares one AXI4-Stream APU read port between N_SRC event sources, round-robin per packet.
//   clk, ARESET        : clock, synchronous active-high reset
//   src_en             : per-source enable, only looked at when choosing a winner
//   s_T*               : packed upstream AXI4-Stream buses, source i in slice i
//   m_T*               : downstream AXI4-Stream bus to the APU
//   grant_valid/idx    : a packet is granted, and to which source
//   pkt_done           : pulse on the TLAST handshake
//   err_overlong       : sticky, set when a packet reaches MAX_BEATS beats without TLAST
module apu_event_arbiter #(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned DATA_W    = apu_arb_pkg::DATA_W,
  parameter int unsigned TID_W     = apu_arb_pkg::TID_W,
  parameter int unsigned MAX_BEATS = 64
) (
  input  logic                        clk,
  input  logic                        ARESET,
  input  logic [N_SRC-1:0]            src_en,
  input  logic [N_SRC-1:0]            s_TVALID,
  output logic [N_SRC-1:0]            s_TREADY,
  input  logic [N_SRC*DATA_W-1:0]     s_TDATA,
  input  logic [N_SRC*DATA_W/8-1:0]   s_TSTRB,
  input  logic [N_SRC*DATA_W/8-1:0]   s_TKEEP,
  input  logic [N_SRC-1:0]            s_TLAST,
  input  logic [N_SRC*TID_W-1:0]      s_TID,
  output logic                        m_TVALID,
  input  logic                        m_TREADY,
  output logic [DATA_W-1:0]           m_TDATA,
  output logic [DATA_W/8-1:0]         m_TSTRB,
  output logic [DATA_W/8-1:0]         m_TKEEP,
  output logic                        m_TLAST,
  output logic [TID_W-1:0]            m_TID,
  output logic                        grant_valid,
  output logic [$clog2(N_SRC)-1:0]    grant_idx,
  output logic                        pkt_done,
  output logic                        err_overlong
);

  import apu_arb_pkg::*;

  localparam int unsigned IdxW  = $clog2(N_SRC);
  localparam int unsigned KeepW = DATA_W / 8;
  localparam int unsigned CntW  = $clog2(MAX_BEATS + 1);

  arb_state_t        state_q, state_d;
  logic [IdxW-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]   last_q, last_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              pick_any;
  logic [IdxW-1:0]   pick_idx;
  logic              hs;

  rr_pick #(
    .N (N_SRC)
  ) u_rr_pick (
    .req_i  (s_TVALID & src_en),
    .last_i (last_q),
    .any_o  (pick_any),
    .idx_o  (pick_idx)
  );

  // Zero-latency payload mux; everything is forced to 0 outside PASS.
  always_comb begin
    m_TVALID = 1'b0;
    m_TDATA  = '0;
    m_TSTRB  = '0;
    m_TKEEP  = '0;
    m_TLAST  = 1'b0;
    m_TID    = '0;
    s_TREADY = '0;
    if (state_q == PASS) begin
      m_TVALID          = s_TVALID[grant_q];
      m_TDATA           = s_TDATA[32'(grant_q)*DATA_W +: DATA_W];
      m_TSTRB           = s_TSTRB[32'(grant_q)*KeepW +: KeepW];
      m_TKEEP           = s_TKEEP[32'(grant_q)*KeepW +: KeepW];
      m_TLAST           = s_TLAST[grant_q];
      m_TID             = s_TID[32'(grant_q)*TID_W +: TID_W];
      s_TREADY[grant_q] = m_TREADY;
    end
  end

  assign hs           = m_TVALID & m_TREADY;
  assign pkt_done     = hs & m_TLAST;
  assign grant_valid  = (state_q == PASS);
  assign grant_idx    = (state_q == PASS) ? grant_q : '0;
  assign err_overlong = err_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = PASS;
          grant_d = pick_idx;
          cnt_d   = '0;
        end
      end
      PASS: begin
        if (hs) begin
          if (cnt_q < CntW'(MAX_BEATS)) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (m_TLAST) begin
            state_d = IDLE;
            last_d  = grant_q;
          end else if (cnt_q >= CntW'(MAX_BEATS - 1)) begin
            // This beat brings the count to MAX_BEATS with no TLAST yet.
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ARESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= IdxW'(N_SRC - 1);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_apu_event_arbiter.sv
// Directed bench for apu_event_arbiter: four sources modelled as simple packet FIFOs.
module tb_apu_event_arbiter;

  localparam int unsigned NS = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned TW = 11;
  localparam int unsigned KW = DW / 8;

  logic              clk;
  logic              areset;
  logic [NS-1:0]     src_en;
  logic [NS-1:0]     s_tvalid;
  logic [NS-1:0]     s_tready;
  logic [NS*DW-1:0]  s_tdata;
  logic [NS*KW-1:0]  s_tstrb;
  logic [NS*KW-1:0]  s_tkeep;
  logic [NS-1:0]     s_tlast;
  logic [NS*TW-1:0]  s_tid;
  logic              m_tvalid;
  logic              m_tready;
  logic [DW-1:0]     m_tdata;
  logic [KW-1:0]     m_tstrb;
  logic [KW-1:0]     m_tkeep;
  logic              m_tlast;
  logic [TW-1:0]     m_tid;
  logic              grant_valid;
  logic [1:0]        grant_idx;
  logic              pkt_done;
  logic              err_overlong;

  apu_event_arbiter #(
    .N_SRC     (NS),
    .DATA_W    (DW),
    .TID_W     (TW),
    .MAX_BEATS (4)
  ) dut (
    .clk          (clk),
    .ARESET       (areset),
    .src_en       (src_en),
    .s_TVALID     (s_tvalid),
    .s_TREADY     (s_tready),
    .s_TDATA      (s_tdata),
    .s_TSTRB      (s_tstrb),
    .s_TKEEP      (s_tkeep),
    .s_TLAST      (s_tlast),
    .s_TID        (s_tid),
    .m_TVALID     (m_tvalid),
    .m_TREADY     (m_tready),
    .m_TDATA      (m_tdata),
    .m_TSTRB      (m_tstrb),
    .m_TKEEP      (m_tkeep),
    .m_TLAST      (m_tlast),
    .m_TID        (m_tid),
    .grant_valid  (grant_valid),
    .grant_idx    (grant_idx),
    .pkt_done     (pkt_done),
    .err_overlong (err_overlong)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Source model state: packets remaining, packet length, beat index, packet number, TID.
  int           rem  [NS];
  int           plen [NS];
  int           bi   [NS];
  int           pk   [NS];
  logic [TW-1:0] tid [NS];

  function automatic logic [DW-1:0] beat_word(int src, int pnum, int beat);
    return {8'(src), 8'(pnum), 16'(beat)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      s_tvalid[i]          = (rem[i] > 0);
      s_tdata[i*DW +: DW]  = beat_word(i, pk[i], bi[i]);
      s_tstrb[i*KW +: KW]  = 4'hF;
      s_tkeep[i*KW +: KW]  = 4'(i + 1);
      s_tlast[i]           = (bi[i] == plen[i] - 1);
      s_tid[i*TW +: TW]    = tid[i];
    end
  endtask

  // One clock: sample handshakes before the edge, advance the sources after it.
  task automatic step();
    logic [NS-1:0] hs;
    #1;
    hs = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NS; i++) begin
      if (hs[i]) begin
        if (bi[i] == plen[i] - 1) begin
          bi[i] = 0;
          pk[i] = pk[i] + 1;
          rem[i] = rem[i] - 1;
        end else begin
          bi[i] = bi[i] + 1;
        end
      end
    end
    drive();
    #1;
  endtask

  task automatic flush_sources();
    for (int i = 0; i < NS; i++) begin
      rem[i]  = 0;
      plen[i] = 1;
      bi[i]   = 0;
      pk[i]   = 0;
    end
    drive();
  endtask

  task automatic reset_dut();
    areset   = 1'b1;
    m_tready = 1'b1;
    src_en   = 4'b1111;
    flush_sources();
    step();
    step();
    areset = 1'b0;
    #1;
  endtask

  int exp_order2 [5] = '{0, 1, 2, 3, 0};
  int exp_order4 [4] = '{1, 3, 1, 3};
  logic [DW-1:0] held;

  initial begin
    tid[0] = 11'h010;
    tid[1] = 11'h011;
    tid[2] = 11'h123;
    tid[3] = 11'h013;
    areset = 1'b1;

    // Reset state
    reset_dut();
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_grant_valid", 64'(grant_valid), 64'd0);
    chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd0);
    chk("rst_pkt_done", 64'(pkt_done), 64'd0);
    chk("rst_err", 64'(err_overlong), 64'd0);

    // 1: single source 2, 3 beats, TID 0x123
    rem[2] = 1; plen[2] = 3;
    drive(); #1;
    chk("t1_idle_no_beat", 64'(m_tvalid), 64'd0);
    step();
    chk("t1_grant_valid", 64'(grant_valid), 64'd1);
    chk("t1_grant_idx", 64'(grant_idx), 64'd2);
    chk("t1_s_tready", 64'(s_tready), 64'b0100);
    chk("t1_keep", 64'(m_tkeep), 64'd3);
    for (int b = 0; b < 3; b++) begin
      chk("t1_tvalid", 64'(m_tvalid), 64'd1);
      chk("t1_tid", 64'(m_tid), 64'h123);
      chk("t1_data", 64'(m_tdata), 64'(beat_word(2, 0, b)));
      chk("t1_tlast", 64'(m_tlast), 64'(b == 2));
      chk("t1_pkt_done", 64'(pkt_done), 64'(b == 2));
      step();
    end
    chk("t1_back_idle", 64'(grant_valid), 64'd0);
    chk("t1_idle_tvalid", 64'(m_tvalid), 64'd0);

    // 2: all sources busy, 2-beat packets; one bubble between packets
    reset_dut();
    for (int i = 0; i < NS; i++) begin
      rem[i] = 3; plen[i] = 2;
    end
    drive();
    for (int p = 0; p < 5; p++) begin
      step();
      chk("t2_grant_valid", 64'(grant_valid), 64'd1);
      chk("t2_grant_idx", 64'(grant_idx), 64'(exp_order2[p]));
      chk("t2_data0", 64'(m_tdata), 64'(beat_word(exp_order2[p], p / 4, 0)));
      step();
      chk("t2_pkt_done", 64'(pkt_done), 64'd1);
      step();
      chk("t2_bubble", 64'(grant_valid), 64'd0);
    end
    flush_sources();

    // 3: source 1, downstream stalls 5 cycles on beat 1
    reset_dut();
    rem[1] = 1; plen[1] = 4;
    drive();
    step();
    chk("t3_grant_idx", 64'(grant_idx), 64'd1);
    step();
    m_tready = 1'b0;
    #1;
    held = m_tdata;
    chk("t3_held_beat1", 64'(held), 64'(beat_word(1, 0, 1)));
    for (int c = 0; c < 5; c++) begin
      chk("t3_stall_s_tready", 64'(s_tready), 64'd0);
      chk("t3_stall_tvalid", 64'(m_tvalid), 64'd1);
      chk("t3_stall_data", 64'(m_tdata), 64'(beat_word(1, 0, 1)));
      chk("t3_stall_tid", 64'(m_tid), 64'h011);
      step();
    end
    m_tready = 1'b1;
    #1;
    chk("t3_resume_s_tready", 64'(s_tready), 64'b0010);
    step();
    chk("t3_beat2", 64'(m_tdata), 64'(beat_word(1, 0, 2)));
    step();
    chk("t3_beat3", 64'(m_tdata), 64'(beat_word(1, 0, 3)));
    chk("t3_pkt_done", 64'(pkt_done), 64'd1);
    step();
    chk("t3_idle", 64'(grant_valid), 64'd0);

    // 4: only sources 1 and 3 enabled
    reset_dut();
    src_en = 4'b1010;
    for (int i = 0; i < NS; i++) begin
      rem[i] = 3; plen[i] = 1;
    end
    drive();
    for (int p = 0; p < 4; p++) begin
      step();
      chk("t4_grant_valid", 64'(grant_valid), 64'd1);
      chk("t4_grant_idx", 64'(grant_idx), 64'(exp_order4[p]));
      chk("t4_pkt_done", 64'(pkt_done), 64'd1);
      step();
      chk("t4_bubble", 64'(grant_valid), 64'd0);
    end
    flush_sources();

    // 5: 6-beat packet against MAX_BEATS=4
    reset_dut();
    rem[0] = 1; plen[0] = 6;
    drive();
    step();
    for (int b = 0; b < 6; b++) begin
      chk("t5_data", 64'(m_tdata), 64'(beat_word(0, 0, b)));
      chk("t5_err", 64'(err_overlong), 64'(b >= 4));
      chk("t5_pkt_done", 64'(pkt_done), 64'(b == 5));
      step();
    end
    chk("t5_idle", 64'(grant_valid), 64'd0);
    chk("t5_err_sticky", 64'(err_overlong), 64'd1);
    step();
    chk("t5_err_sticky2", 64'(err_overlong), 64'd1);

    // 6: reset during beat 2 of 4 on source 2
    reset_dut();
    chk("t6_err_cleared", 64'(err_overlong), 64'd0);
    rem[2] = 1; plen[2] = 4;
    drive();
    step();
    chk("t6_grant_idx", 64'(grant_idx), 64'd2);
    step();
    chk("t6_beat2", 64'(m_tdata), 64'(beat_word(2, 0, 1)));
    areset = 1'b1;
    step();
    chk("t6_rst_grant_valid", 64'(grant_valid), 64'd0);
    chk("t6_rst_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_rst_s_tready", 64'(s_tready), 64'd0);
    chk("t6_rst_pkt_done", 64'(pkt_done), 64'd0);
    areset = 1'b0;
    flush_sources();
    rem[0] = 1; rem[2] = 1;
    drive();
    step();
    chk("t6_next_grant_valid", 64'(grant_valid), 64'd1);
    chk("t6_next_grant_idx", 64'(grant_idx), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
